cp0_unit: RTL and testbench

CP0_UNIT -- requirements
Module: cp0_unit

---
 rtl/cp0_unit.sv | 105 ++++++++++
 tb/tb_cp0_unit.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cp0_unit.sv
// MIPS-style coprocessor 0 holding SR, Cause and EPC, with exception/interrupt capture.
// Optional macro CP0_PRID_EN adds a read-only PRId register at address 15.
module cp0_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_in,
    output logic [31:0] cp0_out,
    input  logic [31:0] vpc,
    input  logic        bd_in,
    input  logic [4:0]  exc_code_in,
    input  logic [5:0]  hw_int,
    input  logic        exl_clr,
    output logic [31:0] epc_out,
    output logic        req
);
    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
`ifdef CP0_PRID_EN
    localparam logic [4:0]  ADDR_PRID = 5'd15;
    localparam logic [31:0] PRID_VAL  = 32'h0000_0007;
`endif

    logic [5:0]  im_q, im_d;
    logic        ie_q, ie_d;
    logic        exl_q, exl_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req, exc_req;
    logic [31:0] sr_rd, cause_rd;

    assign int_req = (|(hw_int & im_q)) & ie_q & ~exl_q;
    assign exc_req = (exc_code_in != 5'd0) & ~exl_q;
    assign req     = int_req | exc_req;
    assign epc_out = epc_q;

    always_comb begin
        im_d  = im_q;
        ie_d  = ie_q;
        exl_d = exl_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        ip_d  = hw_int;
        if (req) begin
            // Capture wins over any mtc0 in the same cycle; the write is simply lost.
            exl_d = 1'b1;
            exc_d = int_req ? 5'd0 : exc_code_in;
            bd_d  = bd_in;
            epc_d = bd_in ? (vpc - 32'd4) : vpc;
        end else begin
            if (we && cp0_addr == ADDR_SR) begin
                im_d  = cp0_in[15:10];
                exl_d = cp0_in[1];
                ie_d  = cp0_in[0];
            end
            if (we && cp0_addr == ADDR_EPC)
                epc_d = cp0_in;
            // eret overrides the EXL bit of a coincident SR write.
            if (exl_clr)
                exl_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= '0;
            ie_q  <= 1'b0;
            exl_q <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            ie_q  <= ie_d;
            exl_q <= exl_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    assign sr_rd    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_rd = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};

    always_comb begin
        cp0_out = 32'd0;
        case (cp0_addr)
            ADDR_SR:    cp0_out = sr_rd;
            ADDR_CAUSE: cp0_out = cause_rd;
            ADDR_EPC:   cp0_out = epc_q;
`ifdef CP0_PRID_EN
            ADDR_PRID:  cp0_out = PRID_VAL;
`endif
            default:    cp0_out = 32'd0;
        endcase
    end
endmodule

// File: tb/tb_cp0_unit.sv
// Scoreboard bench for cp0_unit: expected register images are queued with each
// stimulus and popped as the matching reads are taken.
module tb_cp0_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_in;
    logic [31:0] cp0_out;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic [5:0]  hw_int;
    logic        exl_clr;
    logic [31:0] epc_out;
    logic        req;

    int total = 0;
    int bad   = 0;

    logic [31:0] exp_q[$];
    logic [4:0]  addr_q[$];

`ifdef CP0_PRID_EN
    localparam logic [31:0] PRID_EXP = 32'h0000_0007;
`else
    localparam logic [31:0] PRID_EXP = 32'h0000_0000;
`endif

    cp0_unit dut (
        .clk(clk), .reset(reset), .we(we), .cp0_addr(cp0_addr), .cp0_in(cp0_in),
        .cp0_out(cp0_out), .vpc(vpc), .bd_in(bd_in), .exc_code_in(exc_code_in),
        .hw_int(hw_int), .exl_clr(exl_clr), .epc_out(epc_out), .req(req)
    );

    always #5 clk = ~clk;

    task automatic idle();
        we = 0; cp0_addr = 5'd0; cp0_in = 0; vpc = 0; bd_in = 0;
        exc_code_in = 0; hw_int = 0; exl_clr = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic push(input logic [4:0] a, input logic [31:0] e);
        addr_q.push_back(a);
        exp_q.push_back(e);
    endtask

    // Drains the scoreboard: reads each queued address and compares inline.
    task automatic drain(input string tag);
        logic [4:0]  a;
        logic [31:0] e;
        while (exp_q.size() > 0) begin
            a = addr_q.pop_front();
            e = exp_q.pop_front();
            cp0_addr = a; #1;
            total++;
            if (cp0_out !== e) begin
                bad++;
                $display("FAIL %s addr=%0d got=%h exp=%h", tag, a, cp0_out, e);
            end
        end
    endtask

    task automatic test_reset();
        idle(); reset = 0;
        #12;
        total++;
        if (req !== 1'b0 || epc_out !== 32'd0) begin
            bad++; $display("FAIL reset_outs req=%b epc=%h exp req=0 epc=0", req, epc_out);
        end
        push(12, 0); push(13, 0); push(14, 0); push(15, PRID_EXP);
        drain("reset_regs");
        @(negedge clk); reset = 1;
        step();
    endtask

    task automatic eret();
        idle(); exl_clr = 1; step(); idle();
    endtask

    task automatic test_ov();
        idle(); exc_code_in = 5'd12; vpc = 32'h3000; #1;
        total++;
        if (req !== 1'b1) begin bad++; $display("FAIL ov_req got=%b exp=1", req); end
        step();
        total++;
        if (req !== 1'b0 || epc_out !== 32'h3000) begin
            bad++; $display("FAIL ov_after req=%b epc=%h exp req=0 epc=00003000", req, epc_out);
        end
        exc_code_in = 0;
        push(12, 32'h2); push(13, 32'h30); push(14, 32'h3000);
        drain("ov_regs");
        eret();
        push(12, 32'h0);
        drain("ov_eret");
    endtask

    task automatic test_delay_slot();
        idle(); exc_code_in = 5'd10; vpc = 32'h3010; bd_in = 1; step(); idle();
        push(13, 32'h8000_0028); push(14, 32'h300C);
        drain("bd_regs");
        eret();
        // vpc-4 wraps through zero
        exc_code_in = 5'd8; vpc = 32'h2; bd_in = 1; step(); idle();
        push(14, 32'hFFFF_FFFE);
        drain("bd_wrap");
        eret();
    endtask

    task automatic test_int_priority();
        idle(); we = 1; cp0_addr = 12; cp0_in = 32'h0000_0401; step(); idle();
        hw_int = 6'b000001; exc_code_in = 5'd4; vpc = 32'h3030; #1;
        total++;
        if (req !== 1'b1) begin bad++; $display("FAIL int_req got=%b exp=1", req); end
        step();
        exc_code_in = 0;
        push(13, 32'h0000_0400); push(12, 32'h0000_0403); push(14, 32'h3030);
        drain("int_regs");
        hw_int = 0; step();
        push(13, 32'h0);
        drain("int_ip_follow");
        // SR write coinciding with eret: written EXL=1 is forced back to 0
        we = 1; cp0_addr = 12; cp0_in = 32'h0000_0003; exl_clr = 1; step(); idle();
        push(12, 32'h0000_0001);
        drain("sr_eret_coincide");
        we = 1; cp0_addr = 12; cp0_in = 0; step(); idle();
    endtask

    task automatic test_write_drop();
        idle(); we = 1; cp0_addr = 14; cp0_in = 32'h1234; exc_code_in = 5'd8; vpc = 32'h3020;
        step(); idle();
        push(14, 32'h3020); push(13, 32'h20);
        drain("drop_regs");
        eret();
        we = 1; cp0_addr = 14; cp0_in = 32'hDEAD_BEEF; #1;
        total++;
        if (cp0_out !== 32'h3020) begin
            bad++; $display("FAIL no_bypass got=%h exp=00003020", cp0_out);
        end
        step(); idle();
        push(14, 32'hDEAD_BEEF);
        drain("epc_write");
        // Cause and PRId ignore mtc0
        we = 1; cp0_addr = 13; cp0_in = 32'hFFFF_FFFF; step();
        cp0_addr = 15; step(); idle();
        push(13, 32'h20); push(15, PRID_EXP); push(0, 0); push(31, 0);
        drain("ro_unimpl");
    endtask

    task automatic test_back_to_back();
        idle(); exc_code_in = 5'd12; vpc = 32'h4000; step();
        exc_code_in = 5'd10; vpc = 32'h5000; bd_in = 1; hw_int = 6'b111111; #1;
        total++;
        if (req !== 1'b0) begin bad++; $display("FAIL nested_req got=%b exp=0", req); end
        step(); idle();
        push(14, 32'h4000); push(13, 32'h0000_FC30);
        drain("nested_regs");
    endtask

    task automatic test_async_reset();
        // EXL is still set from the previous task; reset lands between edges.
        @(posedge clk); #3;
        reset = 0; #1;
        total++;
        if (epc_out !== 32'd0 || req !== 1'b0) begin
            bad++; $display("FAIL async_outs epc=%h req=%b exp epc=0 req=0", epc_out, req);
        end
        push(12, 0); push(13, 0); push(14, 0);
        drain("async_regs");
        @(negedge clk); reset = 1;
        step();
    endtask

    initial begin
        test_reset();
        test_ov();
        test_delay_slot();
        test_int_priority();
        test_write_drop();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
